// File: rtl/hfosc_power_sequencer.sv
// Power/enable sequencer for the 48 MHz HF oscillator, clocked from the always-on slow clock.
// Raises hf_pu, then hf_en after a settle delay, then flags hf_ready. Powers down after an idle hold.
module hfosc_power_sequencer #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PU_CYCLES   = 2,
  parameter int unsigned EN_CYCLES   = 3,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             force_on,
  output logic             hf_pu,
  output logic             hf_en,
  output logic             hf_ready,
  output logic [N_REQ-1:0] ack,
  output logic [2:0]       state,
  output logic [7:0]       wake_cnt
);

  localparam int unsigned WAKE_W = 8;
  localparam logic [CNT_W-1:0]  PU_LOAD   = CNT_W'(PU_CYCLES - 1);
  localparam logic [CNT_W-1:0]  EN_LOAD   = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_MAX  = '1;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_POWERUP = 3'd1,
    ST_ENABLE  = 3'd2,
    ST_RUN     = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAKE_W-1:0] wake_q, wake_d;
  logic              pu_q, pu_d;
  logic              en_q, en_d;
  logic              rdy_q, rdy_d;
  logic              any_req;

  assign any_req = (|req) | force_on;

  // Next state, delay counter, wake counter, and output decode of the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wake_d  = wake_q;
    case (state_q)
      ST_OFF: begin
        if (any_req) begin
          state_d = ST_POWERUP;
          cnt_d   = PU_LOAD;
          if (wake_q != WAKE_MAX) wake_d = wake_q + WAKE_W'(1);
        end
      end
      ST_POWERUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ENABLE;
          cnt_d   = EN_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ENABLE: begin
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RUN: begin
        if (!any_req) begin
          state_d = ST_HOLD;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_HOLD: begin
        // A new request wins over the idle timeout so the clock never glitches off.
        if (any_req)           state_d = ST_RUN;
        else if (cnt_q == '0)  state_d = ST_OFF;
        else                   cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
    pu_d  = (state_d == ST_POWERUP) || (state_d == ST_ENABLE) ||
            (state_d == ST_RUN)     || (state_d == ST_HOLD);
    en_d  = (state_d == ST_ENABLE)  || (state_d == ST_RUN) || (state_d == ST_HOLD);
    rdy_d = (state_d == ST_RUN)     || (state_d == ST_HOLD);
  end

  // State, counters and registered outputs; reset stops the oscillator immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      wake_q  <= '0;
      pu_q    <= 1'b0;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wake_q  <= wake_d;
      pu_q    <= pu_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
    end
  end

  assign hf_pu    = pu_q;
  assign hf_en    = en_q;
  assign hf_ready = rdy_q;
  assign state    = state_q;
  assign wake_cnt = wake_q;
  assign ack      = req & {N_REQ{rdy_q}};

endmodule

// File: tb/tb_hfosc_power_sequencer.sv
// Scoreboard bench for hfosc_power_sequencer: a timeline reference model predicts every cycle.
module tb_hfosc_power_sequencer;

  localparam int PU   = 2;
  localparam int EN   = 3;
  localparam int IDLE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       force_on = 1'b0;
  logic       hf_pu, hf_en, hf_ready;
  logic [1:0] ack;
  logic [2:0] state;
  logic [7:0] wake_cnt;

  hfosc_power_sequencer #(
    .N_REQ(2), .CNT_W(8), .PU_CYCLES(PU), .EN_CYCLES(EN), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .force_on(force_on),
    .hf_pu(hf_pu), .hf_en(hf_en), .hf_ready(hf_ready),
    .ack(ack), .state(state), .wake_cnt(wake_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [2:0] st;
    logic       pu;
    logic       en;
    logic       rdy;
    logic [1:0] ack;
    logic [7:0] wake;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: tracks the wake edge and the edge the release began, in absolute edge numbers.
  int n_edge  = 0;
  bit m_on    = 0;
  int t_wake  = 0;
  int t_rel   = -1;
  int m_wakes = 0;

  task automatic model_step(input logic r, input logic [1:0] q, input logic f);
    exp_t e;
    int   d;
    bit   a;
    a = (q != 2'b00) || f;
    n_edge++;
    if (r) begin
      m_on = 0; m_wakes = 0; t_rel = -1;
    end else if (!m_on) begin
      if (a) begin
        m_on = 1; t_wake = n_edge; t_rel = -1;
        m_wakes = (m_wakes < 255) ? m_wakes + 1 : 255;
      end
    end else if (n_edge - t_wake > PU + EN) begin
      if (a)               t_rel = -1;
      else if (t_rel < 0)  t_rel = n_edge;
      else if (n_edge - t_rel >= IDLE) m_on = 0;
    end
    e.edge_no = n_edge;
    e.wake    = 8'(m_wakes);
    if (!m_on) begin
      e.st = 3'd0; e.pu = 0; e.en = 0; e.rdy = 0;
    end else begin
      d = n_edge - t_wake;
      if (d < PU)           begin e.st = 3'd1; e.pu = 1; e.en = 0; e.rdy = 0; end
      else if (d < PU + EN) begin e.st = 3'd2; e.pu = 1; e.en = 1; e.rdy = 0; end
      else                  begin e.st = (t_rel < 0) ? 3'd3 : 3'd4; e.pu = 1; e.en = 1; e.rdy = 1; end
    end
    e.ack = e.rdy ? q : 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int edge_no, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s edge %0d: got %0h expected %0h", name, edge_no, got, want);
    end
  endtask

  // Drive inputs on the falling edge and record the prediction for the next rising edge.
  task automatic drive(input logic r, input logic [1:0] q, input logic f, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = r; req = q; force_on = f;
      model_step(r, q, f);
    end
  endtask

  // Monitor: after every rising edge pop one prediction and compare all outputs.
  initial begin
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("state",    e.edge_no, 8'(state),    8'(e.st));
        check("hf_pu",    e.edge_no, 8'(hf_pu),    8'(e.pu));
        check("hf_en",    e.edge_no, 8'(hf_en),    8'(e.en));
        check("hf_ready", e.edge_no, 8'(hf_ready), 8'(e.rdy));
        check("ack",      e.edge_no, 8'(ack),      8'(e.ack));
        check("wake_cnt", e.edge_no, wake_cnt,     e.wake);
        check("ack_without_ready", e.edge_no, 8'(ack != 2'b00 && !hf_ready), 8'd0);
      end
    end
  end

  // Stimulus: directed scenarios, randomized traffic, then wake counter saturation.
  initial begin
    int         len;
    logic [1:0] rq;
    logic       fo, rs;
    drive(1'b1, 2'b00, 1'b0, 3);
    // Request, release into HOLD, re-request from HOLD, then full release.
    drive(1'b0, 2'b01, 1'b0, 10);
    drive(1'b0, 2'b00, 1'b0, 2);
    drive(1'b0, 2'b10, 1'b0, 4);
    drive(1'b0, 2'b00, 1'b0, 6);
    // Single-cycle pulse still runs the whole sequence.
    drive(1'b0, 2'b01, 1'b0, 1);
    drive(1'b0, 2'b00, 1'b0, 11);
    // Reset while in ENABLE, then force_on alone.
    drive(1'b0, 2'b11, 1'b0, 3);
    drive(1'b1, 2'b11, 1'b0, 1);
    drive(1'b0, 2'b00, 1'b0, 1);
    drive(1'b0, 2'b00, 1'b1, 8);
    drive(1'b0, 2'b00, 1'b0, 6);
    // Randomized traffic with occasional force_on and reset.
    for (int k = 0; k < 120; k++) begin
      len = $urandom_range(1, 8);
      rq  = 2'($urandom_range(0, 3));
      fo  = ($urandom_range(0, 7) == 0);
      rs  = ($urandom_range(0, 39) == 0);
      drive(rs, rq, fo, rs ? 1 : len);
    end
    drive(1'b1, 2'b00, 1'b0, 1);
    // 300 wake-ups: wake counter must stick at 255.
    for (int k = 0; k < 300; k++) begin
      drive(1'b0, 2'($urandom_range(1, 3)), 1'b0, 1);
      drive(1'b0, 2'b00, 1'b0, 11);
    end
    @(posedge clk);
    #2;
    check("wake_saturated", n_edge, wake_cnt, 8'd255);
    check("final_off", n_edge, 8'({hf_pu, hf_en, hf_ready}), 8'd0);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
